// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: ID redirect/stall controls, instruction memory port, IF/ID register view.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline and memory.
interface if_fetch_unit_if;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        j_en;
    logic [25:0] j_index;
    logic        jr_en;
    logic [31:0] jr_target;
    logic [7:0]  im_addr;
    logic [31:0] im_data;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign;
    logic [31:0] fetch_count;

    modport master (
        input  stall, br_taken, br_offset, j_en, j_index, jr_en, jr_target, im_data,
        output im_addr, pc, if_id_instr, if_id_pc4, if_id_valid, misalign, fetch_count
    );

    modport slave (
        output stall, br_taken, br_offset, j_en, j_index, jr_en, jr_target, im_data,
        input  im_addr, pc, if_id_instr, if_id_pc4, if_id_valid, misalign, fetch_count
    );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: PC, combinational imem address, IF/ID register; word at pc=A lands in IF/ID one edge later.
// stall holds PC and IF/ID; an ID redirect overrides stall, loads the target and squashes the fetch.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    if_fetch_unit_if.master bus
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] redirect_target;
    logic        redirect;

    // Targets are relative to the instruction sitting in ID, i.e. the IF/ID register.
    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        br_target = if_id_q.pc4 + {{14{bus.br_offset[15]}}, bus.br_offset, 2'b00};
        j_target  = {if_id_q.pc4[31:28], bus.j_index, 2'b00};
        redirect  = bus.jr_en | bus.j_en | bus.br_taken;

        redirect_target = br_target;
        if (bus.jr_en) begin
            redirect_target = bus.jr_target;
        end else if (bus.j_en) begin
            redirect_target = j_target;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        if_id_d       = if_id_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;

        if (redirect) begin
            pc_d          = {redirect_target[31:2], 2'b00};
            if_id_d.instr = NOP_WORD;
            if_id_d.valid = 1'b0;
            misalign_d    = misalign_q | (redirect_target[1:0] != 2'b00);
        end else if (!bus.stall) begin
            pc_d          = pc_plus4;
            if_id_d.instr = bus.im_data;
            if_id_d.pc4   = pc_plus4;
            if_id_d.valid = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_id_q       <= '{instr: NOP_WORD, pc4: 32'd0, valid: 1'b0};
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            if_id_q       <= if_id_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.im_addr     = pc_q[7:0];
    assign bus.pc          = pc_q;
    assign bus.if_id_instr = if_id_q.instr;
    assign bus.if_id_pc4   = if_id_q.pc4;
    assign bus.if_id_valid = if_id_q.valid;
    assign bus.misalign    = misalign_q;
    assign bus.fetch_count = fetch_count_q;

endmodule
